// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges ID/EX/MEM stall requests, runs the
// multi-cycle unit handshake with a watchdog, and sequences redirect flushes.
// Optional stalled-cycle counter enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_mc_req,
  input  logic        mc_done,
  input  logic        mem_busy,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_start,
  output logic        mc_cancel,
  output logic        timeout_err,
  output logic [31:0] stall_cnt
);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [7:0] TMO        = 8'(MC_TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wd_q, wd_d;
  logic        done_pend_q, done_pend_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        mc_start_q, mc_start_d;
  logic        mc_cancel_q, mc_cancel_d;
  logic        timeout_err_q, timeout_err_d;
  logic        done_ok;
  logic        tmo_hit;

  // A done in the first MC_WAIT cycle coincides with mc_start and cannot be real.
  assign done_ok = (state_q == MC_WAIT) &&
                   ((mc_done && (wd_q != 8'd1)) || done_pend_q);
  assign tmo_hit = (state_q == MC_WAIT) && !done_ok && (wd_q == TMO);

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    done_pend_d   = done_pend_q;
    flush_d       = 1'b0;
    new_pc_d      = new_pc_q;
    mc_start_d    = 1'b0;
    mc_cancel_d   = 1'b0;
    timeout_err_d = 1'b0;
    stall         = STALL_NONE;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          stall = STALL_MEM;
        end else if (ex_mc_req && !flush_req) begin
          stall = STALL_EX;
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end
        if (ex_mc_req) begin
          state_d    = MC_WAIT;
          wd_d       = 8'd1;
          mc_start_d = 1'b1;
        end
      end

      MC_WAIT: begin
        if (mem_busy) begin
          stall = STALL_MEM;
        end else if (done_ok || tmo_hit) begin
          stall = STALL_NONE;
        end else begin
          stall = STALL_EX;
        end

        if (done_ok && !mem_busy) begin
          state_d     = RUN;
          wd_d        = 8'd0;
          done_pend_d = 1'b0;
        end else if (done_ok) begin
          // Result held until ex_mem can capture it; watchdog frozen meanwhile.
          done_pend_d = 1'b1;
        end else if (tmo_hit) begin
          state_d       = RUN;
          wd_d          = 8'd0;
          mc_cancel_d   = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end

      FLUSH: begin
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Redirect overrides everything decided above for the next cycle.
    if (flush_req) begin
      state_d       = FLUSH;
      flush_d       = 1'b1;
      new_pc_d      = flush_pc;
      mc_start_d    = 1'b0;
      timeout_err_d = 1'b0;
      mc_cancel_d   = (state_q == MC_WAIT);
      wd_d          = 8'd0;
      done_pend_d   = 1'b0;
    end

    if (rst) begin
      stall = STALL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wd_q          <= 8'd0;
      done_pend_q   <= 1'b0;
      flush_q       <= 1'b0;
      new_pc_q      <= 32'h0000_0000;
      mc_start_q    <= 1'b0;
      mc_cancel_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      done_pend_q   <= done_pend_d;
      flush_q       <= flush_d;
      new_pc_q      <= new_pc_d;
      mc_start_q    <= mc_start_d;
      mc_cancel_q   <= mc_cancel_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign flush       = flush_q;
  assign new_pc      = new_pc_q;
  assign mc_start    = mc_start_q;
  assign mc_cancel   = mc_cancel_q;
  assign timeout_err = timeout_err_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage integer core. Merges stall requests from ID, EX (multi-cycle operations) and MEM (data-memory wait) into the per-stage `stall[5:0]` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. Runs the start/done handshake with the multi-cycle unit (divider), guarded by a watchdog. Sequences exception flushes with a redirect PC.

## Interface

Parameters:
- `MC_TIMEOUT`, default 64: maximum cycles in the multi-cycle wait before abort; legal range 2..255.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `stallreq_id`  in  1  ID needs a hold (load-use hazard).
- `ex_mc_req`  in  1  EX holds a multi-cycle op and needs the unit.
- `mc_done`  in  1  one-cycle pulse: the multi-cycle result is valid.
- `mem_busy`  in  1  data memory not ready this cycle.
- `flush_req`  in  1  exception or redirect request.
- `flush_pc`  in  32  redirect target, sampled together with `flush_req`.
- `stall`  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb. Combinational.
- `flush`  out  1  registered one-cycle flush of all pipeline registers.
- `new_pc`  out  32  registered redirect PC; valid while `flush` = 1.
- `mc_start`  out  1  registered one-cycle start pulse to the multi-cycle unit.
- `mc_cancel`  out  1  registered one-cycle abort pulse to the multi-cycle unit.
- `timeout_err`  out  1  registered one-cycle pulse on watchdog expiry.
- `stall_cnt`  out  32  stalled-cycle counter (see Configuration).

## Operation

- States: RUN, MC_WAIT, FLUSH.
- Stall encodings:
  - none: 000000
  - ID: 000111
  - EX: 001111
  - MEM: 011111
- Priority, highest first: FLUSH state > `mem_busy` > multi-cycle (MC_WAIT, or `ex_mc_req` in RUN) > `stallreq_id`.
- **RUN**
  - `ex_mc_req` = 1 and `flush_req` = 0: `stall` = EX this cycle. Next state MC_WAIT, with `mc_start` = 1 in the first MC_WAIT cycle.
- **MC_WAIT**
  - `stall` = EX, or MEM if `mem_busy` = 1.
  - 8-bit watchdog counts MC_WAIT cycles, starting at 1 on entry.
  - `mc_done` = 1 with `mem_busy` = 0: `stall` = 000000 that cycle (ex_mem captures the result); next state RUN.
  - `mc_done` = 1 with `mem_busy` = 1: set `done_pend`; stay in MC_WAIT. Exit in the first cycle with `mem_busy` = 0, with `stall` = 000000 in that cycle.
  - `ex_mc_req` is ignored in the exit cycle.
  - Watchdog reaches MC_TIMEOUT with no done:
    - `stall` = 000000 that cycle.
    - Next cycle: `mc_cancel` = 1 and `timeout_err` = 1.
    - Next state RUN.
- **flush_req** (any state, highest priority)
  - Next state FLUSH; `new_pc` <= `flush_pc`.
  - If the current state is MC_WAIT: `mc_cancel` = 1 in the next cycle, and `done_pend` and the watchdog are cleared.
- **FLUSH**
  - Lasts exactly one cycle: `flush` = 1, `stall` = 000000. Next state RUN.
  - A `flush_req` during FLUSH re-enters FLUSH with the new `flush_pc`.
  - `ex_mc_req` during FLUSH is ignored.
- **Reset**
  - State RUN; watchdog, `done_pend` and `stall_cnt` cleared.
  - `flush`, `mc_start`, `mc_cancel` and `timeout_err` = 0; `new_pc` = 0x00000000.
  - `stall` forced to 000000 while `rst` = 1.
  - Reset during MC_WAIT aborts without `mc_cancel`; the unit is reset by the same `rst`.

## Timing

- `stall` is combinational from state, watchdog and inputs, with zero latency.
- Registered pulses (`flush`, `mc_start`, `mc_cancel`, `timeout_err`) are high for exactly one cycle and never repeat without a new trigger.
- Minimum multi-cycle op: request at cycle N, `mc_start` at N+1, earliest `mc_done` honoured at N+2.
- `mc_done` in RUN or FLUSH is ignored.
- Flush latency: `flush_req` at cycle N gives `flush` and `new_pc` at N+1, and RUN at N+2.

## Configuration

- `PIPE_CTRL_STALL_CNT_EN` defined: `stall_cnt` increments by 1 on every cycle with `stall[0]` = 1 and `rst` = 0. It saturates at 0xFFFFFFFF and is cleared only by reset.
- `PIPE_CTRL_STALL_CNT_EN` undefined: the `stall_cnt` port exists and is tied to 0; no counter flops are inferred.

## Test plan

- **ID hazard:** `stallreq_id` = 1 for 2 cycles -> `stall` = 000111 for exactly those 2 cycles, then 000000; no pulses.
- **Divider op:** `ex_mc_req` at N, `mc_done` at N+5 -> `stall` = 001111 for N..N+4 and 000000 at N+5; `mc_start` = 1 only at N+1; state RUN at N+6.
- **Done under memory wait:** `mc_done` at N+3 while `mem_busy` = 1 for N+2..N+4 -> `stall` = 011111 for N+2..N+4 and 000000 at N+5; the result is not lost.
- **Timeout:** MC_TIMEOUT = 4 and `mc_done` never asserted -> `stall` released on the 4th MC_WAIT cycle; `mc_cancel` = `timeout_err` = 1 on the next cycle.
- **Flush mid-op:** `flush_req` with `flush_pc` = 0x00000180 during MC_WAIT -> next cycle `flush` = 1, `new_pc` = 0x00000180, `mc_cancel` = 1, `stall` = 000000; a later `mc_done` is ignored.
- **Counter and reset:** with the macro defined, 7 stalled cycles -> `stall_cnt` = 7. `rst` pulse in MC_WAIT -> all outputs 0 next cycle and `stall_cnt` = 0.
